// File: rtl/mips16_mc_pkg.sv
// Shared encodings for the MIPS16 multi-cycle controller: state codes,
// opcodes and the datapath mux/ALU-class encodings.
package mips16_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_EXEC_I   = 4'd10,
    S_JR       = 4'd11,
    S_ERROR    = 4'd12
  } state_t;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ORI   = 3'b001;
  localparam logic [2:0] OP_J     = 3'b010;
  localparam logic [2:0] OP_JAL   = 3'b011;
  localparam logic [2:0] OP_LW    = 3'b100;
  localparam logic [2:0] OP_SW    = 3'b101;
  localparam logic [2:0] OP_BEQ   = 3'b110;
  localparam logic [2:0] OP_ADDI  = 3'b111;

  localparam logic [1:0] ALUOP_FUNCT = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_LOGIC = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_TWO    = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_JR     = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  localparam int WAIT_W = 8;

  // States that own a memory access and therefore watch mem_ready.
  function automatic logic is_wait_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mips16_mc_control_if.sv
// Controller <-> datapath bundle: instruction fields and status in,
// enables/selects and controller status out.
interface mips16_mc_control_if;
  logic [2:0] opcode;
  logic [3:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       alu_src_a;
  logic       sign_or_zero;
  logic [3:0] state;
  logic       instr_done;
  logic       timeout_err;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
           reg_write, reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source,
           alu_src_a, sign_or_zero, state, instr_done, timeout_err
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
           reg_write, reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source,
           alu_src_a, sign_or_zero, state, instr_done, timeout_err
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Memory wait counter: cleared on state entry, counts stalled cycles and
// flags when the next stalled cycle would exhaust the allowed budget.
module mc_wait_timer
  import mips16_mc_pkg::*;
#(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic count_en,
  output logic terminal
);

  localparam logic [WAIT_W-1:0] TERM = WAIT_W'(LIMIT - 1);

  logic [WAIT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (count_en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // True during the LIMIT-th stalled cycle; a stall then is a timeout.
  assign terminal = (count_reg >= TERM);

endmodule

// File: rtl/mips16_mc_control.sv
// Multi-cycle MIPS16 control FSM with bounded memory waits and a sticky
// timeout error state left only through reset.
module mips16_mc_control
  import mips16_mc_pkg::*;
#(
  parameter int         MEM_TIMEOUT = 15,
  parameter logic [3:0] JR_FUNCT    = 4'b1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mips16_mc_control_if.master  bus
);

  state_t state_reg;
  state_t state_next;
  logic   wait_expired;
  logic   stalled;

  assign stalled = is_wait_state(state_reg) && !bus.mem_ready;

  mc_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (state_next != state_reg),
    .count_en (stalled),
    .terminal (wait_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_FETCH: begin
        if (bus.mem_ready)     state_next = S_DECODE;
        else if (wait_expired) state_next = S_ERROR;
      end
      S_DECODE: begin
        unique case (bus.opcode)
          OP_RTYPE:        state_next = (bus.funct == JR_FUNCT) ? S_JR : S_EXEC_R;
          OP_ORI, OP_ADDI: state_next = S_EXEC_I;
          OP_J, OP_JAL:    state_next = S_JUMP;
          OP_LW, OP_SW:    state_next = S_MEM_ADDR;
          default:         state_next = S_BRANCH;
        endcase
      end
      S_MEM_ADDR: begin
        if (bus.opcode == OP_LW)      state_next = S_MEM_RD;
        else if (bus.opcode == OP_SW) state_next = S_MEM_WR;
        else                          state_next = S_FETCH;
      end
      S_MEM_RD: begin
        if (bus.mem_ready)     state_next = S_MEM_WB;
        else if (wait_expired) state_next = S_ERROR;
      end
      S_MEM_WR: begin
        if (bus.mem_ready)     state_next = S_FETCH;
        else if (wait_expired) state_next = S_ERROR;
      end
      S_EXEC_R, S_EXEC_I:                     state_next = S_ALU_WB;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP, S_JR: state_next = S_FETCH;
      S_ERROR:                                state_next = S_ERROR;
      default:                                state_next = S_FETCH;
    endcase
  end

  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.ir_write      = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = REGDST_RT;
    bus.mem_to_reg    = M2R_ALU;
    bus.alu_src_b     = SRCB_REG;
    bus.alu_op        = ALUOP_FUNCT;
    bus.pc_source     = PCSRC_ALU;
    bus.alu_src_a     = 1'b0;
    bus.sign_or_zero  = 1'b1;
    bus.instr_done    = 1'b0;
    bus.timeout_err   = 1'b0;

    unique case (state_reg)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = SRCB_TWO;
        bus.alu_op    = ALUOP_ADD;
        // Reset is asynchronous, so the completion strobes are gated with it
        // to keep a held reset from latching IR or advancing PC.
        bus.ir_write  = bus.mem_ready && reset_n;
        bus.pc_write  = bus.mem_ready && reset_n;
      end
      S_DECODE: begin
        bus.alu_src_b = SRCB_IMM_SH;
        bus.alu_op    = ALUOP_ADD;
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = M2R_MEM;
        bus.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_write  = 1'b1;
        bus.i_or_d     = 1'b1;
        bus.instr_done = bus.mem_ready;
      end
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
      end
      S_EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        if (bus.opcode == OP_ORI) begin
          bus.alu_op       = ALUOP_LOGIC;
          bus.sign_or_zero = 1'b0;
        end else begin
          bus.alu_op       = ALUOP_ADD;
        end
      end
      S_ALU_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = (bus.opcode == OP_RTYPE) ? REGDST_RD : REGDST_RT;
        bus.instr_done = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALUOP_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = PCSRC_ALUOUT;
        bus.instr_done    = 1'b1;
      end
      S_JUMP: begin
        bus.pc_write   = 1'b1;
        bus.pc_source  = PCSRC_JUMP;
        bus.instr_done = 1'b1;
        if (bus.opcode == OP_JAL) begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = REGDST_RA;
          bus.mem_to_reg = M2R_PC;
        end
      end
      S_JR: begin
        bus.pc_write   = 1'b1;
        bus.pc_source  = PCSRC_JR;
        bus.instr_done = 1'b1;
      end
      S_ERROR: begin
        bus.timeout_err = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.state = state_reg;

endmodule

// File: tb/tb_mips16_mc_control.sv
// Directed bench for the multi-cycle controller: walks each instruction
// class cycle by cycle against hand-written state/output vectors.
module tb_mips16_mc_control;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mips16_mc_control_if bus ();

  mips16_mc_control #(
    .MEM_TIMEOUT (15),
    .JR_FUNCT    (4'b1000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // {pc_write,pc_write_cond,ir_write,i_or_d,mem_read,mem_write,reg_write,
  //  reg_dst,mem_to_reg,alu_src_b,alu_op,pc_source,alu_src_a,sign_or_zero,
  //  instr_done,timeout_err}
  localparam logic [20:0] V_FETCH_RDY  = {7'b1010100, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [20:0] V_FETCH_WAIT = {7'b0000100, 2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [20:0] V_DECODE     = {7'b0000000, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [20:0] V_MEM_ADDR   = {7'b0000000, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [20:0] V_MEM_RD     = {7'b0001100, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [20:0] V_MEM_WB     = {7'b0000001, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [20:0] V_MEM_WR_RDY = {7'b0001010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [20:0] V_MEM_WR_WT  = {7'b0001010, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [20:0] V_ALU_WB_I   = {7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [20:0] V_ALU_WB_R   = {7'b0000001, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [20:0] V_EXEC_R     = {7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [20:0] V_ADDI       = {7'b0000000, 2'b00, 2'b00, 2'b10, 2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [20:0] V_ORI        = {7'b0000000, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] V_BRANCH     = {7'b0100000, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam logic [20:0] V_J          = {7'b1000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [20:0] V_JAL        = {7'b1000001, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [20:0] V_JR         = {7'b1000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam logic [20:0] V_ERROR      = {7'b0000000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1};

  function automatic logic [20:0] outs();
    return {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.i_or_d, bus.mem_read,
            bus.mem_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_b,
            bus.alu_op, bus.pc_source, bus.alu_src_a, bus.sign_or_zero,
            bus.instr_done, bus.timeout_err};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench 2 time units after the edge that ends reset, so the
  // next rising edge performs the first FETCH cycle.
  task automatic do_reset();
    reset_n       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.zero      = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.mem_ready = 1'b1;
    bus.opcode    = 3'b111;
    bus.funct     = 4'b0000;
    bus.zero      = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (bus.state !== 4'd0 || outs() !== V_FETCH_WAIT) begin
      errors++;
      $display("FAIL reset_held: state=%0d outs=%b, required state=0 outs=%b", bus.state, outs(), V_FETCH_WAIT);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (bus.state !== 4'd0 || outs() !== V_FETCH_RDY) begin
      errors++;
      $display("FAIL reset_release: state=%0d outs=%b, required state=0 outs=%b", bus.state, outs(), V_FETCH_RDY);
    end
    $display("test_reset done");
  endtask

  task automatic test_addi();
    logic [3:0]  st [5] = '{4'd0, 4'd1, 4'd10, 4'd7, 4'd0};
    logic [20:0] ov [5] = '{V_FETCH_RDY, V_DECODE, V_ADDI, V_ALU_WB_I, V_FETCH_RDY};
    do_reset();
    bus.opcode = 3'b111; bus.funct = 4'b0101; bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.state !== st[i] || outs() !== ov[i]) begin
        errors++;
        $display("FAIL addi[%0d]: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outs(), st[i], ov[i]);
      end
      if (i < 4) step();
    end
    $display("test_addi done");
  endtask

  task automatic test_ori_rtype();
    logic [3:0]  st [8] = '{4'd0, 4'd1, 4'd10, 4'd7, 4'd0, 4'd1, 4'd6, 4'd7};
    logic [20:0] ov [8] = '{V_FETCH_RDY, V_DECODE, V_ORI, V_ALU_WB_I,
                            V_FETCH_RDY, V_DECODE, V_EXEC_R, V_ALU_WB_R};
    do_reset();
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.opcode = (i < 4) ? 3'b001 : 3'b000;
      bus.funct  = 4'b0010;
      #1;
      checks++;
      if (bus.state !== st[i] || outs() !== ov[i]) begin
        errors++;
        $display("FAIL ori_rtype[%0d]: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outs(), st[i], ov[i]);
      end
      step();
    end
    $display("test_ori_rtype done");
  endtask

  task automatic test_lw_stall();
    logic        rdy [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0]  st  [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    logic [20:0] ov  [9] = '{V_FETCH_RDY, V_DECODE, V_MEM_ADDR, V_MEM_RD, V_MEM_RD,
                             V_MEM_RD, V_MEM_RD, V_MEM_WB, V_FETCH_RDY};
    do_reset();
    bus.opcode = 3'b100; bus.funct = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      checks++;
      if (bus.state !== st[i] || outs() !== ov[i]) begin
        errors++;
        $display("FAIL lw[%0d]: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outs(), st[i], ov[i]);
      end
      if (i < 8) step();
    end
    $display("test_lw_stall done");
  endtask

  task automatic test_sw();
    logic        rdy [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0]  st  [6] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd0};
    logic [20:0] ov  [6] = '{V_FETCH_RDY, V_DECODE, V_MEM_ADDR, V_MEM_WR_WT, V_MEM_WR_RDY, V_FETCH_RDY};
    do_reset();
    bus.opcode = 3'b101; bus.funct = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      bus.mem_ready = rdy[i];
      #1;
      checks++;
      if (bus.state !== st[i] || outs() !== ov[i]) begin
        errors++;
        $display("FAIL sw[%0d]: state=%0d outs=%b, required state=%0d outs=%b", i, bus.state, outs(), st[i], ov[i]);
      end
      if (i < 5) step();
    end
    $display("test_sw done");
  endtask

  // Branch and jumps; mem_ready is dropped outside memory states to show
  // it has no effect there.
  task automatic test_branch_jump();
    logic [2:0]  op  [4] = '{3'b110, 3'b010, 3'b011, 3'b000};
    logic [3:0]  fn  [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000};
    logic [3:0]  est [4] = '{4'd8, 4'd9, 4'd9, 4'd11};
    logic [20:0] eov [4] = '{V_BRANCH, V_J, V_JAL, V_JR};
    do_reset();
    bus.zero = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.opcode = op[k]; bus.funct = fn[k];
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (bus.state !== 4'd0 || outs() !== V_FETCH_RDY) begin
        errors++;
        $display("FAIL ctl[%0d] fetch: state=%0d outs=%b, required state=0 outs=%b", k, bus.state, outs(), V_FETCH_RDY);
      end
      step();
      bus.mem_ready = 1'b0;
      #1;
      checks++;
      if (bus.state !== 4'd1 || outs() !== V_DECODE) begin
        errors++;
        $display("FAIL ctl[%0d] decode: state=%0d outs=%b, required state=1 outs=%b", k, bus.state, outs(), V_DECODE);
      end
      step();
      #1;
      checks++;
      if (bus.state !== est[k] || outs() !== eov[k]) begin
        errors++;
        $display("FAIL ctl[%0d] exec: state=%0d outs=%b, required state=%0d outs=%b", k, bus.state, outs(), est[k], eov[k]);
      end
      step();
    end
    #1;
    checks++;
    if (bus.state !== 4'd0) begin
      errors++;
      $display("FAIL ctl_return: state=%0d, required 0", bus.state);
    end
    $display("test_branch_jump done");
  endtask

  task automatic test_timeout();
    int n = 0;
    do_reset();
    bus.opcode = 3'b111; bus.funct = 4'b0000; bus.mem_ready = 1'b0;
    #1;
    while (bus.state === 4'd0 && n < 40) begin
      step();
      #1;
      n++;
    end
    checks++;
    if (n !== 15) begin
      errors++;
      $display("FAIL timeout_cycles: fetch lasted %0d cycles, required 15", n);
    end
    checks++;
    if (bus.state !== 4'd12 || outs() !== V_ERROR) begin
      errors++;
      $display("FAIL timeout_error: state=%0d outs=%b, required state=12 outs=%b", bus.state, outs(), V_ERROR);
    end
    bus.mem_ready = 1'b1;
    repeat (3) step();
    #1;
    checks++;
    if (bus.state !== 4'd12 || bus.timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: state=%0d timeout_err=%b, required 12/1", bus.state, bus.timeout_err);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_reset: state=%0d timeout_err=%b, required 0/0", bus.state, bus.timeout_err);
    end
    $display("test_timeout done");
  endtask

  // 14 stalls is the longest legal wait; the counter must restart on entry
  // to MEM_RD after a 10-cycle stall in FETCH.
  task automatic test_wait_boundary();
    int bad = 0;
    do_reset();
    bus.opcode = 3'b100; bus.funct = 4'b0000; bus.mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (bus.state !== 4'd0) bad++;
      step();
    end
    bus.mem_ready = 1'b1;
    step(); step(); step();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (bus.state !== 4'd3 || bus.timeout_err !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL wait_boundary_hold: %0d cycles off expected state, required 0", bad);
    end
    bus.mem_ready = 1'b1;
    step();
    #1;
    checks++;
    if (bus.state !== 4'd4 || outs() !== V_MEM_WB) begin
      errors++;
      $display("FAIL wait_boundary_done: state=%0d outs=%b, required state=4 outs=%b", bus.state, outs(), V_MEM_WB);
    end
    $display("test_wait_boundary done");
  endtask

  task automatic test_reset_mid_sw();
    do_reset();
    bus.opcode = 3'b101; bus.funct = 4'b0000; bus.mem_ready = 1'b1;
    step(); step(); step();
    bus.mem_ready = 1'b0;
    step();
    #1;
    checks++;
    if (bus.state !== 4'd5 || bus.mem_write !== 1'b1) begin
      errors++;
      $display("FAIL mid_sw_setup: state=%0d mem_write=%b, required 5/1", bus.state, bus.mem_write);
    end
    bus.mem_ready = 1'b1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.state !== 4'd0 || outs() !== V_FETCH_WAIT) begin
      errors++;
      $display("FAIL mid_sw_reset: state=%0d outs=%b, required state=0 outs=%b", bus.state, outs(), V_FETCH_WAIT);
    end
    step();
    reset_n = 1'b1;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 14; i++) step();
    #1;
    checks++;
    if (bus.state !== 4'd0 || bus.timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_sw_counter_clear: state=%0d timeout_err=%b, required 0/0", bus.state, bus.timeout_err);
    end
    $display("test_reset_mid_sw done");
  endtask

  initial begin
    bus.opcode = 3'b000; bus.funct = 4'b0000; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    test_reset();
    test_addi();
    test_ori_rtype();
    test_lw_stall();
    test_sw();
    test_branch_jump();
    test_timeout();
    test_wait_boundary();
    test_reset_mid_sw();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips16_mc_control.md
MIPS16_MC_CONTROL -- requirements
Module: mips16_mc_control

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum wait cycles for mem_ready per memory state; legal range 1..255.
REQ-002 SHALL have parameter JR_FUNCT, default 4'b1000: funct value that marks jr under opcode 000.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 opcode  in  3  instruction register bits [15:13]; stable from DECODE onward.
REQ-006 funct  in  4  instruction register bits [3:0].
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  shared memory completes the current access this cycle.
REQ-009 pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, reg_write  out  1 each  datapath enables; i_or_d=1 selects the ALUOut address.
REQ-010 reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source  out  2 each  datapath mux selects and ALU class.
REQ-011 alu_src_a, sign_or_zero  out  1 each  A-source select (0=PC, 1=rs); 1=sign-extend immediate.
REQ-012 state  out  4  current state code; instr_done  out  1  last-cycle pulse; timeout_err  out  1  sticky error.

Function
REQ-013 SHALL implement states FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, ALU_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, JR=11, ERROR=12.
REQ-014 Output defaults in every state: all enables 0, all selects 0, sign_or_zero=1.
REQ-015 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01 (constant 2), alu_op=11; ir_write and pc_write SHALL assert only in the cycle where mem_ready=1; then -> DECODE.
REQ-016 DECODE: alu_src_a=0, alu_src_b=11 (imm<<1), alu_op=11. Next: 000 with funct==JR_FUNCT -> JR; other 000 -> EXEC_R; 001/111 -> EXEC_I; 010/011 -> JUMP; 100/101 -> MEM_ADDR; 110 -> BRANCH.
REQ-017 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=11; next MEM_RD for 100, MEM_WR for 101.
REQ-018 MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready, then MEM_WB. MEM_WB: reg_write=1, mem_to_reg=01, reg_dst=00, instr_done=1; -> FETCH.
REQ-019 MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready; instr_done=1 in the mem_ready cycle; -> FETCH.
REQ-020 EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=00; -> ALU_WB. EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=10 and sign_or_zero=0 for 001, alu_op=11 for 111; -> ALU_WB.
REQ-021 ALU_WB: reg_write=1, mem_to_reg=00, reg_dst=01 for opcode 000 else 00, instr_done=1; -> FETCH.
REQ-022 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1; -> FETCH.
REQ-023 JUMP: pc_write=1, pc_source=10, instr_done=1; for 011 also reg_write=1, reg_dst=10, mem_to_reg=10. JR: pc_write=1, pc_source=11, instr_done=1; both -> FETCH.
REQ-024 Wait counter SHALL clear on entry to FETCH/MEM_RD/MEM_WR and increment each cycle mem_ready=0 there; reaching MEM_TIMEOUT with mem_ready=0 -> ERROR.
REQ-025 ERROR: all outputs default, timeout_err=1, no exit except reset.
REQ-026 mem_ready outside FETCH/MEM_RD/MEM_WR SHALL be ignored.
REQ-027 Cycle counts with mem_ready=1 immediately: R/I 4, lw 5, sw 4, beq/j/jal/jr 3.

Reset
REQ-028 reset_n=0 SHALL immediately force state=FETCH, wait count 0, timeout_err=0, outputs to REQ-014 defaults except FETCH mem_read/i_or_d/ALU selects, regardless of an in-progress access.
REQ-029 First FETCH access SHALL begin on the first rising clk after reset_n deasserts.

Structure
REQ-030 Package mips16_mc_pkg SHALL hold state enum, opcode constants, alu_op, alu_src_b and pc_source encodings.
REQ-031 One sub-module mc_wait_timer (clear, count-enable, terminal flag) SHALL implement the REQ-024 counter.

Verification
REQ-032 addi (opcode 111), mem_ready tied 1 -> states 0,1,10,7; reg_write=1 only in ALU_WB, alu_op=11.
REQ-033 lw, mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then MEM_WB with mem_to_reg=01, instr_done 1 cycle.
REQ-034 beq, zero=1 -> BRANCH drives pc_write_cond=1, pc_source=01; next state FETCH after 3 cycles.
REQ-035 opcode 000, funct 1000 -> DECODE->JR, pc_source=11, no reg_write.
REQ-036 mem_ready held 0 in FETCH, MEM_TIMEOUT=15 -> ERROR after 15 cycles, timeout_err=1 until reset_n low.
REQ-037 reset_n low mid-MEM_WR -> same-cycle mem_write=0, state=0, timeout_err=0.
